// File: rtl/axi_rd_line_buf_pkg.sv
// rtl/axi_rd_line_buf_pkg.sv - shared constants, state encoding and helpers for the HDMI read line buffer
package axi_rd_line_buf_pkg;

  localparam int DATA_W_DEF    = 256;
  localparam int PIX_W_DEF     = 16;
  localparam int BURST_LEN_DEF = 20;
  localparam int H_PIX_DEF     = 1280;
  localparam int V_LINES_DEF   = 720;

  localparam int PIX_PER_BEAT = DATA_W_DEF / PIX_W_DEF;
  localparam int FRAME_BURSTS = H_PIX_DEF * V_LINES_DEF / (PIX_PER_BEAT * BURST_LEN_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Pointer width with an extra wrap bit so full and empty are distinguishable
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int frame_bursts(input int h_pix, input int v_lines,
                                      input int pix_per_beat, input int burst_len);
    return h_pix * v_lines / (pix_per_beat * burst_len);
  endfunction

endpackage

// File: rtl/sync_fifo_beat.sv
// rtl/sync_fifo_beat.sv - single-clock beat FIFO with synchronous read and occupancy count
module sync_fifo_beat
  import axi_rd_line_buf_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [ptr_w(DEPTH)-1:0]   count
);

  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign count = wr_ptr - rd_ptr;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage array, no reset needed for the data itself
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[PW-2:0]] <= wr_data;
    end
  end

  // Pointer update; clr empties the FIFO in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered read port: data appears the cycle after rd_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (do_rd) begin
      rd_data <= mem[rd_ptr[PW-2:0]];
    end
  end

endmodule

// File: rtl/axi_rd_line_buf.sv
// rtl/axi_rd_line_buf.sv - AXI read-burst line buffer feeding one HDMI pixel per clock
module axi_rd_line_buf
  import axi_rd_line_buf_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int PIX_W     = 16,
  parameter int BURST_LEN = 20,
  parameter int DEPTH     = 128,
  parameter int H_PIX     = 1280,
  parameter int V_LINES   = 720
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hdmi_vsync,
  input  logic              hdmi_href,
  output logic              rd_req,
  input  logic              rd_req_ack,
  input  logic              axi_rvalid,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic              axi_rlast,
  output logic              axi_rready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic              overflow
);

  localparam int PPB = DATA_W / PIX_W;
  localparam int FB  = frame_bursts(H_PIX, V_LINES, PPB, BURST_LEN);
  localparam int PW  = ptr_w(DEPTH);
  localparam int IW  = $clog2(PPB);
  localparam int BW  = $clog2(FB + 1);

  state_t            state;
  logic              vsync_q;
  logic              href_q;
  logic              vsync_rise;
  logic              href_fall;
  logic [1:0]        outstanding;
  logic [BW-1:0]     burst_cnt;

  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_clr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_rdata;

  logic [DATA_W-1:0] hold_data;
  logic              hold_valid;
  logic              pf_valid;
  logic              pf_take;
  logic [IW-1:0]     pix_idx;
  logic              cur_valid;
  logic [DATA_W-1:0] cur_data;
  logic              beat_done;

  logic              ack_take;
  logic              rlast_dec;
  logic [PW-1:0]     fifo_cnt_nx;
  logic [1:0]        out_nx;
  logic [BW-1:0]     burst_nx;
  logic              req_rule;

  assign vsync_rise = hdmi_vsync && !vsync_q;
  assign href_fall  = href_q && !hdmi_href;

  // Flush completes once every in-flight burst has drained
  assign fifo_clr = (state == ST_FLUSH) && (outstanding == 2'd0);
  assign fifo_wr  = (state == ST_RUN) && axi_rvalid && !fifo_full;
  assign fifo_rd  = (state == ST_RUN) && !fifo_empty && (!pf_valid || pf_take);

  assign ack_take  = rd_req && rd_req_ack;
  assign rlast_dec = axi_rvalid && axi_rlast && ((outstanding != 2'd0) || ack_take);

  // Credit check is done on next-cycle values so a registered rd_req never over-commits
  assign fifo_cnt_nx = fifo_count + PW'(fifo_wr) - PW'(fifo_rd);
  assign out_nx      = outstanding + 2'(ack_take) - 2'(rlast_dec);
  assign burst_nx    = burst_cnt + BW'(ack_take);
  assign req_rule    = ((32'(DEPTH) - 32'(fifo_cnt_nx)) >= ((32'(out_nx) + 32'd1) * 32'(BURST_LEN)))
                    && (out_nx < 2'd2)
                    && (32'(burst_nx) < 32'(FB));

  // Current beat: holding register first, else the prefetched FIFO output
  assign cur_valid = hold_valid || pf_valid;
  assign cur_data  = hold_valid ? hold_data : fifo_rdata;
  assign beat_done = hdmi_href && (pix_idx == IW'(PPB - 1));

  // Decide whether the prefetched beat is consumed this cycle
  always_comb begin
    pf_take = 1'b0;
    if (hold_valid) begin
      pf_take = beat_done && pf_valid;
    end else begin
      pf_take = pf_valid;
    end
  end

  sync_fifo_beat #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data (axi_rdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Frame state machine with burst request credit and overflow tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      vsync_q     <= 1'b0;
      rd_req      <= 1'b0;
      axi_rready  <= 1'b0;
      outstanding <= 2'd0;
      burst_cnt   <= '0;
      overflow    <= 1'b0;
    end else begin
      vsync_q     <= hdmi_vsync;
      axi_rready  <= 1'b1;
      outstanding <= out_nx;
      burst_cnt   <= burst_nx;
      case (state)
        ST_IDLE: begin
          rd_req <= 1'b0;
          if (vsync_rise) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          rd_req <= 1'b0;
          if (outstanding == 2'd0) begin
            burst_cnt <= '0;
            overflow  <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (axi_rvalid && fifo_full) overflow <= 1'b1;
          if (vsync_rise) begin
            rd_req <= 1'b0;
            state  <= ST_FLUSH;
          end else begin
            rd_req <= (rd_req && !rd_req_ack) || req_rule;
          end
        end
        default: begin
          rd_req <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Beat unpacker: holding register, prefetch tracking and pixel output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_q     <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_idx    <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      pf_valid   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      href_q    <= hdmi_href;
      pix_valid <= hdmi_href;
      if (hdmi_href) begin
        pix_data <= cur_valid ? cur_data[pix_idx*PIX_W +: PIX_W] : '0;
        if (!cur_valid) underflow <= 1'b1;
        pix_idx <= pix_idx + 1'b1;
      end else begin
        pix_data <= '0;
        if (href_fall) pix_idx <= '0;
      end

      if (hold_valid) begin
        if (beat_done) begin
          hold_valid <= pf_valid;
          if (pf_valid) hold_data <= fifo_rdata;
        end
      end else if (pf_valid && !beat_done) begin
        hold_valid <= 1'b1;
        hold_data  <= fifo_rdata;
      end

      pf_valid <= fifo_rd || (pf_valid && !pf_take);

      if (fifo_clr) begin
        hold_valid <= 1'b0;
        pf_valid   <= 1'b0;
        pix_idx    <= '0;
        underflow  <= 1'b0;
      end
    end
  end

endmodule
